// File: rtl/hazard_pkg.sv
// Shared definitions for the decode-stage hazard scoreboard.
// Provides default geometry, the scoreboard entry layout for that geometry,
// and the width helper for stage-select fields.
package hazard_pkg;

  localparam int unsigned DEPTH_DEF      = 3;
  localparam int unsigned LOAD_STAGE_DEF = 2;
  localparam int unsigned RAW_DEF        = 5;
  localparam int unsigned FSEL_W         = $clog2(DEPTH_DEF + 1);

  // One in-flight register write: which rd, and the first stage whose
  // stage_result slice carries its value.
  typedef struct packed {
    logic                valid;
    logic [RAW_DEF-1:0]  rd;
    logic [FSEL_W-1:0]   ready_stage;
  } entry_t;

  function automatic int unsigned fsel_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_fwd_mux.sv
// Operand forwarding selector for one source register.
// Ports:
//   match_i        per-stage match (bit k-1 = stage k)
//   ready_i        per-stage ready_stage fields, FW bits each
//   stage_result_i per-stage results, DW bits each
//   rf_data_i      register-file read data
//   operand_o      resolved operand
//   hazard_o       youngest match cannot be forwarded yet
module fwd_mux
  import hazard_pkg::*;
#(
  parameter int unsigned DW     = 32,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned FW     = fsel_width(DEPTH),
  parameter int unsigned FWD_EN = 1
) (
  input  logic [DEPTH-1:0]    match_i,
  input  logic [DEPTH*FW-1:0] ready_i,
  input  logic [DEPTH*DW-1:0] stage_result_i,
  input  logic [DW-1:0]       rf_data_i,
  output logic [DW-1:0]       operand_o,
  output logic                hazard_o
);

  logic found;

  // Scan from stage 1 upward; only the youngest match decides.
  always_comb begin
    operand_o = rf_data_i;
    hazard_o  = 1'b0;
    found     = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (!found && match_i[k]) begin
        found = 1'b1;
        if (FWD_EN != 0 && FW'(k + 1) >= ready_i[k*FW +: FW]) begin
          operand_o = stage_result_i[k*DW +: DW];
        end else begin
          hazard_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard and forwarding controller.
// Tracks in-flight register writes for DEPTH stages after decode, forwards
// operands, raises load-use/RAW stalls and branch flushes, and counts them.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   issue_valid_i                 decode holds a real instruction
//   rs1_i/rs2_i, rs*_used_i       source registers and whether they are read
//   rd_i, regwrite_i, is_load_i   destination info of the decode instruction
//   rd1_i/rd2_i                   register-file read data
//   stage_result_i                stage k result at [k*DW-1:(k-1)*DW]
//   branch_taken_i, ext_stall_i   branch resolved in EX, external freeze
//   op_a_o/op_b_o                 resolved operands
//   stall_o, bubble_o, flush_o    pipeline control
//   stall_cnt_o, flush_cnt_o      saturating performance counters
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned DW         = 32,
  parameter int unsigned RAW        = RAW_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned LOAD_STAGE = LOAD_STAGE_DEF,
  parameter int unsigned FWD_EN     = 1,
  parameter int unsigned CW         = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid_i,
  input  logic [RAW-1:0]      rs1_i,
  input  logic [RAW-1:0]      rs2_i,
  input  logic                rs1_used_i,
  input  logic                rs2_used_i,
  input  logic [RAW-1:0]      rd_i,
  input  logic                regwrite_i,
  input  logic                is_load_i,
  input  logic [DW-1:0]       rd1_i,
  input  logic [DW-1:0]       rd2_i,
  input  logic [DEPTH*DW-1:0] stage_result_i,
  input  logic                branch_taken_i,
  input  logic                ext_stall_i,
  output logic [DW-1:0]       op_a_o,
  output logic [DW-1:0]       op_b_o,
  output logic                stall_o,
  output logic                bubble_o,
  output logic                flush_o,
  output logic [CW-1:0]       stall_cnt_o,
  output logic [CW-1:0]       flush_cnt_o
);

  localparam int unsigned FW = fsel_width(DEPTH);

  typedef struct packed {
    logic           valid;
    logic [RAW-1:0] rd;
    logic [FW-1:0]  ready_stage;
  } sb_entry_t;

  // Index 0 describes stage 1 (EX).
  sb_entry_t [DEPTH-1:0] entries_q, entries_d;
  logic [CW-1:0]         stall_cnt_q, stall_cnt_d;
  logic [CW-1:0]         flush_cnt_q, flush_cnt_d;

  logic [DEPTH-1:0]    match_a, match_b;
  logic [DEPTH*FW-1:0] ready_vec;
  logic                haz_a, haz_b, hazard;

  always_comb begin
    match_a   = '0;
    match_b   = '0;
    ready_vec = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      match_a[k] = rs1_used_i && (rs1_i != '0) && entries_q[k].valid && (entries_q[k].rd == rs1_i);
      match_b[k] = rs2_used_i && (rs2_i != '0) && entries_q[k].valid && (entries_q[k].rd == rs2_i);
      ready_vec[k*FW +: FW] = entries_q[k].ready_stage;
    end
  end

  fwd_mux #(.DW(DW), .DEPTH(DEPTH), .FW(FW), .FWD_EN(FWD_EN)) u_fwd_a (
    .match_i        (match_a),
    .ready_i        (ready_vec),
    .stage_result_i (stage_result_i),
    .rf_data_i      (rd1_i),
    .operand_o      (op_a_o),
    .hazard_o       (haz_a)
  );

  fwd_mux #(.DW(DW), .DEPTH(DEPTH), .FW(FW), .FWD_EN(FWD_EN)) u_fwd_b (
    .match_i        (match_b),
    .ready_i        (ready_vec),
    .stage_result_i (stage_result_i),
    .rf_data_i      (rd2_i),
    .operand_o      (op_b_o),
    .hazard_o       (haz_b)
  );

  // A bubble in decode can never be the victim of a hazard.
  assign hazard = issue_valid_i && (haz_a || haz_b);

  always_comb begin
    stall_o  = 1'b0;
    bubble_o = 1'b0;
    flush_o  = 1'b0;
    if (ext_stall_i) begin
      stall_o = 1'b1;
    end else if (branch_taken_i) begin
      flush_o  = 1'b1;
      bubble_o = 1'b1;
    end else if (hazard) begin
      stall_o  = 1'b1;
      bubble_o = 1'b1;
    end
  end

  always_comb begin
    entries_d   = entries_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!ext_stall_i) begin
      for (int unsigned k = 1; k < DEPTH; k++) begin
        entries_d[k] = entries_q[k-1];
      end
      entries_d[0].valid       = issue_valid_i && regwrite_i && (rd_i != '0) && !stall_o && !flush_o;
      entries_d[0].rd          = rd_i;
      entries_d[0].ready_stage = is_load_i ? FW'(LOAD_STAGE) : FW'(1);
      if (branch_taken_i) begin
        if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CW'(1);
      end else if (hazard) begin
        if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entries_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      entries_q   <= entries_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule
